// File: rtl/elevator_pkg.sv
// Shared state encodings and default sizing for the elevator floor-sequencing controller.
package elevator_pkg;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR_OPEN = 2'd3;

  localparam int DEF_NUM_FLOORS = 4;
  localparam int DEF_FLOOR_W    = 2;
  localparam int DEF_DOOR_TICKS = 3;
endpackage

// File: rtl/elevator_ctrl_if.sv
// Request/status bundle between the elevator controller and its neighbours (divider, buttons, display).
interface elevator_ctrl_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
);
  logic                  clk_1Hz;
  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    floor;
  logic                  door_open;
  logic                  dir_up;
  logic                  moving;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output clk_1Hz, req,
    input  floor, door_open, dir_up, moving, pending
  );

  modport slave (
    input  clk_1Hz, req,
    output floor, door_open, dir_up, moving, pending
  );
endinterface

// File: rtl/elevator_ctrl_tick.sv
// Two-flop synchroniser plus registered rising-edge detector; emits a one-cycle tick per rising edge
// of a slow square wave sampled as data.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic tick_o
);
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick_o = sync2_q & ~prev_q;
endmodule

// File: rtl/elevator_ctrl.sv
// SCAN-order elevator controller: latches floor requests, steps one floor per 1 Hz tick and
// holds the door for DOOR_TICKS ticks. All outputs are registered.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W,
  parameter int DOOR_TICKS = DEF_DOOR_TICKS
)(
  input  logic             clk_100MHz,
  input  logic             reset,
  elevator_ctrl_if.slave   bus
);
  localparam int                  CNT_W = $clog2(DOOR_TICKS + 1);
  localparam logic [CNT_W-1:0]    LOAD  = CNT_W'(DOOR_TICKS);
  localparam logic [FLOOR_W-1:0]  TOP   = FLOOR_W'(NUM_FLOORS - 1);

  logic                  tick;
  logic [1:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clr;
  logic [NUM_FLOORS-1:0] above, below;
  logic                  any_above, any_below, ahead, behind;
  logic                  door_q, moving_q;

  tick_edge_detect u_tick (
    .clk    (clk_100MHz),
    .rst    (reset),
    .sig_i  (bus.clk_1Hz),
    .tick_o (tick)
  );

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i] = pending_q[i] && (i > int'(floor_q));
      below[i] = pending_q[i] && (i < int'(floor_q));
    end
    any_above = |above;
    any_below = |below;
    ahead     = dir_q ? any_above : any_below;
    behind    = dir_q ? any_below : any_above;
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d = DOOR_OPEN;
          cnt_d   = LOAD;
        end else if (any_above && (dir_q || !any_below)) begin
          dir_d   = 1'b1;
          state_d = MOVE_UP;
        end else if (any_below) begin
          dir_d   = 1'b0;
          state_d = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (tick) begin
          if (floor_q == TOP) begin
            state_d = IDLE;
          end else begin
            floor_d = floor_q + FLOOR_W'(1);
            if (pending_q[floor_d]) begin
              state_d = DOOR_OPEN;
              cnt_d   = LOAD;
            end
          end
        end
      end
      MOVE_DOWN: begin
        if (tick) begin
          if (floor_q == '0) begin
            state_d = IDLE;
          end else begin
            floor_d = floor_q - FLOOR_W'(1);
            if (pending_q[floor_d]) begin
              state_d = DOOR_OPEN;
              cnt_d   = LOAD;
            end
          end
        end
      end
      default: begin
        // A fresh press at this floor beats a closing tick and restarts the hold time.
        if (bus.req[floor_q]) begin
          cnt_d = LOAD;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d = '0;
            if (ahead) begin
              state_d = dir_q ? MOVE_UP : MOVE_DOWN;
            end else if (behind) begin
              dir_d   = ~dir_q;
              state_d = dir_q ? MOVE_DOWN : MOVE_UP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    clr = '0;
    if (state_d == DOOR_OPEN) clr[floor_d] = 1'b1;
    pending_d = (pending_q | bus.req) & ~clr;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
      pending_q <= '0;
      door_q    <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      door_q    <= (state_d == DOOR_OPEN);
      moving_q  <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    end
  end

  assign bus.floor     = floor_q;
  assign bus.door_open = door_q;
  assign bus.dir_up    = dir_q;
  assign bus.moving    = moving_q;
  assign bus.pending   = pending_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: fast 1 Hz stand-in (20-cycle period), hand-computed expectations.
module tb_elevator_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  elevator_ctrl_if #(.NUM_FLOORS(4), .FLOOR_W(2)) bus ();

  elevator_ctrl #(.NUM_FLOORS(4), .FLOOR_W(2), .DOOR_TICKS(3)) u_dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    bus.clk_1Hz = 1'b1;
    step(10);
    bus.clk_1Hz = 1'b0;
    step(10);
  endtask

  task automatic do_reset();
    bus.clk_1Hz = 1'b0;
    bus.req     = '0;
    reset       = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic press(input logic [3:0] r);
    bus.req = r;
    step(1);
    bus.req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.floor !== 2'd0) begin bad++; $display("FAIL rst_floor: got=%0d want=0", bus.floor); end
    total++; if (bus.door_open !== 1'b0) begin bad++; $display("FAIL rst_door: got=%b want=0", bus.door_open); end
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL rst_dir: got=%b want=1", bus.dir_up); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL rst_moving: got=%b want=0", bus.moving); end
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL rst_pending: got=%b want=0000", bus.pending); end
  endtask

  task automatic test_single_request();
    do_reset();
    press(4'b0100);
    total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL sr_pending_latch: got=%b want=0100", bus.pending); end
    step(1);
    total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL sr_moving_start: got=%b want=1", bus.moving); end
    total++; if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL sr_dir: got=%b want=1", bus.dir_up); end
    total++; if (bus.floor !== 2'd0) begin bad++; $display("FAIL sr_floor0: got=%0d want=0", bus.floor); end
    do_tick();
    total++; if (bus.floor !== 2'd1) begin bad++; $display("FAIL sr_floor1: got=%0d want=1", bus.floor); end
    total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL sr_moving1: got=%b want=1", bus.moving); end
    do_tick();
    total++; if (bus.floor !== 2'd2) begin bad++; $display("FAIL sr_floor2: got=%0d want=2", bus.floor); end
    total++; if (bus.door_open !== 1'b1) begin bad++; $display("FAIL sr_door_open: got=%b want=1", bus.door_open); end
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL sr_pending_clr: got=%b want=0000", bus.pending); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL sr_stopped: got=%b want=0", bus.moving); end
    do_tick();
    do_tick();
    total++; if (bus.door_open !== 1'b1) begin bad++; $display("FAIL sr_door_hold: got=%b want=1", bus.door_open); end
    do_tick();
    total++; if (bus.door_open !== 1'b0) begin bad++; $display("FAIL sr_door_close: got=%b want=0", bus.door_open); end
    step(5);
    total++; if (bus.moving !== 1'b0 || bus.floor !== 2'd2) begin
      bad++; $display("FAIL sr_idle: got moving=%b floor=%0d want moving=0 floor=2", bus.moving, bus.floor);
    end
  endtask

  task automatic test_same_floor();
    do_reset();
    press(4'b0001);
    step(1);
    total++; if (bus.door_open !== 1'b1) begin bad++; $display("FAIL sf_door: got=%b want=1", bus.door_open); end
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL sf_pending: got=%b want=0000", bus.pending); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL sf_moving: got=%b want=0", bus.moving); end
    do_tick();
    do_tick();
    do_tick();
    total++; if (bus.door_open !== 1'b0) begin bad++; $display("FAIL sf_close: got=%b want=0", bus.door_open); end
  endtask

  task automatic test_scan_reversal();
    do_reset();
    press(4'b1000);
    step(1);
    do_tick();
    total++; if (bus.floor !== 2'd1) begin bad++; $display("FAIL scan_floor1: got=%0d want=1", bus.floor); end
    press(4'b0001);
    total++; if (bus.pending !== 4'b1001) begin bad++; $display("FAIL scan_pending: got=%b want=1001", bus.pending); end
    do_tick();
    total++; if (bus.floor !== 2'd2 || bus.door_open !== 1'b0) begin
      bad++; $display("FAIL scan_pass2: got floor=%0d door=%b want floor=2 door=0", bus.floor, bus.door_open);
    end
    do_tick();
    total++; if (bus.floor !== 2'd3 || bus.door_open !== 1'b1) begin
      bad++; $display("FAIL scan_stop3: got floor=%0d door=%b want floor=3 door=1", bus.floor, bus.door_open);
    end
    total++; if (bus.pending !== 4'b0001) begin bad++; $display("FAIL scan_pending3: got=%b want=0001", bus.pending); end
    do_tick();
    do_tick();
    do_tick();
    total++; if (bus.dir_up !== 1'b0 || bus.moving !== 1'b1 || bus.door_open !== 1'b0) begin
      bad++; $display("FAIL scan_reverse: got dir=%b moving=%b door=%b want dir=0 moving=1 door=0",
                      bus.dir_up, bus.moving, bus.door_open);
    end
    do_tick();
    total++; if (bus.floor !== 2'd2) begin bad++; $display("FAIL scan_down2: got=%0d want=2", bus.floor); end
    do_tick();
    do_tick();
    total++; if (bus.floor !== 2'd0 || bus.door_open !== 1'b1) begin
      bad++; $display("FAIL scan_arrive0: got floor=%0d door=%b want floor=0 door=1", bus.floor, bus.door_open);
    end
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL scan_pending_end: got=%b want=0000", bus.pending); end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    press(4'b1000);
    step(1);
    do_tick();
    do_tick();
    total++; if (bus.floor !== 2'd2 || bus.moving !== 1'b1) begin
      bad++; $display("FAIL rm_pre: got floor=%0d moving=%b want floor=2 moving=1", bus.floor, bus.moving);
    end
    reset = 1'b1;
    step(1);
    total++; if (bus.floor !== 2'd0) begin bad++; $display("FAIL rm_floor: got=%0d want=0", bus.floor); end
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL rm_pending: got=%b want=0000", bus.pending); end
    total++; if (bus.moving !== 1'b0 || bus.door_open !== 1'b0 || bus.dir_up !== 1'b1) begin
      bad++; $display("FAIL rm_flags: got moving=%b door=%b dir=%b want 0 0 1", bus.moving, bus.door_open, bus.dir_up);
    end
    reset = 1'b0;
    do_tick();
    total++; if (bus.floor !== 2'd0 || bus.moving !== 1'b0) begin
      bad++; $display("FAIL rm_discarded: got floor=%0d moving=%b want floor=0 moving=0", bus.floor, bus.moving);
    end
  endtask

  task automatic test_const_high();
    bus.clk_1Hz = 1'b1;
    bus.req     = '0;
    reset       = 1'b1;
    step(2);
    reset   = 1'b0;
    bus.req = 4'b1000;
    step(1);
    bus.req = '0;
    step(1);
    total++; if (bus.floor !== 2'd0 || bus.moving !== 1'b1) begin
      bad++; $display("FAIL ch_pre_tick: got floor=%0d moving=%b want floor=0 moving=1", bus.floor, bus.moving);
    end
    step(1);
    total++; if (bus.floor !== 2'd1) begin bad++; $display("FAIL ch_first_tick: got=%0d want=1", bus.floor); end
    step(200);
    total++; if (bus.floor !== 2'd1) begin bad++; $display("FAIL ch_held: got=%0d want=1", bus.floor); end
    bus.clk_1Hz = 1'b0;
    step(10);
    total++; if (bus.floor !== 2'd1 || bus.moving !== 1'b1) begin
      bad++; $display("FAIL ch_fall: got floor=%0d moving=%b want floor=1 moving=1", bus.floor, bus.moving);
    end
  endtask

  task automatic test_door_reload();
    do_reset();
    press(4'b0010);
    step(1);
    do_tick();
    total++; if (bus.floor !== 2'd1 || bus.door_open !== 1'b1) begin
      bad++; $display("FAIL dr_open: got floor=%0d door=%b want floor=1 door=1", bus.floor, bus.door_open);
    end
    do_tick();
    do_tick();
    // Counter is now 1; the press lands on the cycle the tick is live.
    bus.clk_1Hz = 1'b1;
    step(2);
    bus.req = 4'b0010;
    step(1);
    bus.req = '0;
    total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL dr_pending_clr: got=%b want=0000", bus.pending); end
    step(7);
    bus.clk_1Hz = 1'b0;
    step(10);
    total++; if (bus.door_open !== 1'b1) begin bad++; $display("FAIL dr_reloaded: got=%b want=1", bus.door_open); end
    do_tick();
    do_tick();
    total++; if (bus.door_open !== 1'b1 || bus.pending !== 4'b0000) begin
      bad++; $display("FAIL dr_hold: got door=%b pending=%b want door=1 pending=0000", bus.door_open, bus.pending);
    end
    do_tick();
    total++; if (bus.door_open !== 1'b0) begin bad++; $display("FAIL dr_close: got=%b want=0", bus.door_open); end
  endtask

  initial begin
    bus.clk_1Hz = 1'b0;
    bus.req     = '0;
    step(1);
    test_reset();
    test_single_request();
    test_same_floor();
    test_scan_reversal();
    test_reset_mid_move();
    test_const_high();
    test_door_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
